// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-side blocks.
//   ps2_state_e   transmitter FSM states
//   STATUS_*      bit positions inside the transmitter status word
//   PS2_CMD_*     common host-to-device command bytes
//   odd_parity()  parity bit that makes the 9-bit (data + parity) group odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } ps2_state_e;

  localparam int STATUS_BUSY       = 0;
  localparam int STATUS_ACK_ERR    = 1;
  localparam int STATUS_TIMEOUT    = 2;
  localparam int STATUS_RETRIES_LO = 4;
  localparam int STATUS_RETRIES_HI = 5;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam logic [1:0] RETRY_LIMIT = 2'd2;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchroniser and falling-edge detector for the PS/2 pins.
// Shared by the scancode receiver and the host transmitter.
// Ports:
//   clock, reset      CPU clock, async active-low reset
//   ps2_clk_in        raw PS2 clock pin level
//   ps2_dat_in        raw PS2 data pin level
//   clk_sync          synchronised clock level
//   dat_sync          synchronised data level
//   clk_fall          one-cycle pulse: synchronised clock went high -> low
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_sr_q, clk_sr_d;
  logic [SYNC_STAGES-1:0] dat_sr_q, dat_sr_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sr_d    = clk_sr_q;
    dat_sr_d    = dat_sr_q;
    clk_sr_d[0] = ps2_clk_in;
    dat_sr_d[0] = ps2_dat_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      clk_sr_d[i] = clk_sr_q[i-1];
      dat_sr_d[i] = dat_sr_q[i-1];
    end
    clk_prev_d = clk_sr_q[SYNC_STAGES-1];
  end

  // Idle PS/2 lines are pulled high, so reset the chains to 1 to avoid a
  // phantom falling edge right after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sr_q   <= '1;
      dat_sr_q   <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sr_q   <= clk_sr_d;
      dat_sr_q   <= dat_sr_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_sync = clk_sr_q[SYNC_STAGES-1];
  assign dat_sync = dat_sr_q[SYNC_STAGES-1];
  assign clk_fall = clk_prev_q & ~clk_sync;

endmodule

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command transmitter.
// Performs request-to-send (clock inhibit), shifts data/parity/stop on
// device clock falling edges, checks the device ACK, and reports status.
// Ports:
//   clock, reset              CPU clock, async active-low reset
//   read, write               CPU bus strobes
//   command_cs                command register select (write: data_in[7:0])
//   status_cs                 status register select (read)
//   data_in[31:0]             CPU write data
//   data_out[31:0]            status word while status_cs && read, else 0
//   data_out_valid            status_cs && read
//   busy                      transfer in progress
//   ps2_clock, ps2_data       open-drain pins (drive 0 or release)
// Status word: [0] busy, [1] ack_error, [2] timeout, [5:4] retries used.
// Build option PS2_TX_RETRY_EN: on NACK/timeout, re-send the same byte up
// to two more times; error bits only reflect the final attempt.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, waiting for a command write
// INHIBIT   | holding ps2_clock low; start bit driven on the last cycle
// DATA      | placing data bits LSB first on each clock falling edge
// PARITY    | placing the odd parity bit on the next falling edge
// STOP      | releasing data (stop bit) on the next falling edge
// ACK       | sampling the device ACK on the 11th falling edge
// WAIT_IDLE | waiting for both lines to return high
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1500,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        command_cs,
  input  logic        status_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        busy,
  inout  wire         ps2_clock,
  inout  wire         ps2_data
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  // INHIBIT_CYCLES must be at least 2: the start bit goes out one cycle
  // before the clock is released.
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             parity_q, parity_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;
  logic             clk_low_q, clk_low_d;
  logic             dat_low_q, dat_low_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic clk_sync, dat_sync, clk_fall;
  logic in_frame, timeout_hit, nack, retry_ok;
  logic unused_data_hi;

  assign unused_data_hi = ^data_in[31:8];

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk_in(ps2_clock),
    .ps2_dat_in(ps2_data),
    .clk_sync  (clk_sync),
    .dat_sync  (dat_sync),
    .clk_fall  (clk_fall)
  );

  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    ack_err_d   = ack_err_q;
    timeout_d   = timeout_q;
    clk_low_d   = clk_low_q;
    dat_low_d   = dat_low_q;
`ifdef PS2_TX_RETRY_EN
    retry_d     = retry_q;
    retry_ok    = (retry_q != RETRY_LIMIT);
`else
    retry_ok    = 1'b0;
`endif
    nack        = 1'b0;
    in_frame    = (state_q inside {DATA, PARITY, STOP, ACK, WAIT_IDLE});
    timeout_hit = in_frame && (to_cnt_q == TO_LAST);

    if (in_frame && !timeout_hit) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (write && command_cs) begin
          tx_byte_d = data_in[7:0];
          parity_d  = odd_parity(data_in[7:0]);
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          inh_cnt_d = '0;
          clk_low_d = 1'b1;
          dat_low_d = 1'b0;
          state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_START) begin
          dat_low_d = 1'b1;
        end
        if (inh_cnt_q == INH_LAST) begin
          clk_low_d = 1'b0;
          bit_idx_d = 3'd0;
          to_cnt_d  = '0;
          state_d   = DATA;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      DATA: begin
        if (clk_fall) begin
          dat_low_d = ~tx_byte_q[bit_idx_q];
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      PARITY: begin
        if (clk_fall) begin
          dat_low_d = ~parity_q;
          state_d   = STOP;
        end
      end

      STOP: begin
        if (clk_fall) begin
          dat_low_d = 1'b0;
          state_d   = ACK;
        end
      end

      ACK: begin
        if (clk_fall) begin
          if (dat_sync) begin
            nack = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
      end
    endcase

    // Failure handling overrides whatever the state decode chose above, so a
    // timeout wins over a falling edge landing in the same cycle.
    if (timeout_hit || nack) begin
      if (retry_ok) begin
`ifdef PS2_TX_RETRY_EN
        retry_d = retry_q + 2'd1;
`endif
        inh_cnt_d = '0;
        clk_low_d = 1'b1;
        dat_low_d = 1'b0;
        state_d   = INHIBIT;
      end else if (timeout_hit) begin
        timeout_d = 1'b1;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        state_d   = IDLE;
      end else begin
        ack_err_d = 1'b1;
        state_d   = WAIT_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_byte_q <= 8'h00;
      parity_q  <= 1'b0;
      bit_idx_q <= 3'd0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Pin drives come straight from flops: glitch-free, and an async reset
  // releases both lines immediately.
  assign ps2_clock = clk_low_q ? 1'b0 : 1'bz;
  assign ps2_data  = dat_low_q ? 1'b0 : 1'bz;

  assign busy = (state_q != IDLE);

  logic [31:0] status;
  always_comb begin
    status                 = 32'h0;
    status[STATUS_BUSY]    = busy;
    status[STATUS_ACK_ERR] = ack_err_q;
    status[STATUS_TIMEOUT] = timeout_q;
`ifdef PS2_TX_RETRY_EN
    status[STATUS_RETRIES_HI:STATUS_RETRIES_LO] = retry_q;
`endif
  end

  assign data_out_valid = status_cs && read;
  assign data_out       = data_out_valid ? status : 32'h0;

endmodule

// File: tb/tb_ps2_transmitter.sv
module tb_ps2_transmitter;
  import ps2_pkg::*;

  localparam int INH  = 1500;
  localparam int TO   = 4000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, cmd_cs = 1'b0, st_cs = 1'b0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        dvalid, busy;
  wire         ps2_clk, ps2_dat;
  logic        dev_clk_low = 1'b0, dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .read          (rd),
    .write         (wr),
    .command_cs    (cmd_cs),
    .status_cs     (st_cs),
    .data_in       (din),
    .data_out      (dout),
    .data_out_valid(dvalid),
    .busy          (busy),
    .ps2_clock     (ps2_clk),
    .ps2_data      (ps2_dat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    st_cs = 1'b1;
    rd    = 1'b1;
    #1;
    check({name, " valid"}, {31'b0, dvalid}, 32'h1);
    check(name, dout, exp);
    st_cs = 1'b0;
    rd    = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);
  endtask

  task automatic write_cmd(input logic [7:0] b, input bit accepted);
    wr     = 1'b1;
    cmd_cs = 1'b1;
    din    = {24'hA5A5A5, b};
    @(negedge clk);
    wr     = 1'b0;
    cmd_cs = 1'b0;
    if (accepted) push_frame(b);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy === 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, " busy cleared"}, {31'b0, busy}, 32'h0);
  endtask

  // Device model: measures the inhibit, checks the start bit, then clocks
  // out nclk clocks, comparing each sampled bit with the scoreboard.
  task automatic dev_frame(input int nclk, input bit ack,
                           output int low_cnt, output int rel_cyc);
    int   t = 0;
    logic e;
    low_cnt = 0;
    rel_cyc = cyc;
    while (ps2_clk !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("inhibit seen", {31'b0, ps2_clk}, 32'h0);
    if (ps2_clk !== 1'b0) return;
    while (ps2_clk === 1'b0 && low_cnt < 5000) begin
      low_cnt++;
      @(negedge clk);
    end
    rel_cyc = cyc;
    check("start bit", {31'b0, ps2_dat}, 32'h0);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= nclk && k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      check($sformatf("sb nonempty bit %0d", k), {31'b0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("frame bit %0d", k), {31'b0, ps2_dat}, {31'b0, e});
      end
      repeat (HALF) @(negedge clk);
    end
    if (nclk >= 11) begin
      if (ack) dev_dat_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          nclk;
    bit          ack;
    bit          busy_write;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int low_cnt, rel_cyc;

    vecs[0] = '{cmd: PS2_CMD_SET_LEDS, nclk: 11, ack: 1'b1, busy_write: 1'b0, exp_status: 32'h0};
    vecs[1] = '{cmd: 8'h01,            nclk: 11, ack: 1'b0, busy_write: 1'b0, exp_status: 32'h2};
    vecs[2] = '{cmd: PS2_CMD_RESET,    nclk: 4,  ack: 1'b1, busy_write: 1'b0, exp_status: 32'h4};
    vecs[3] = '{cmd: PS2_CMD_ENABLE,   nclk: 11, ack: 1'b1, busy_write: 1'b1, exp_status: 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset ps2_clock", {31'b0, ps2_clk}, 32'h1);
    check("reset ps2_data", {31'b0, ps2_dat}, 32'h1);
    check("idle data_out", dout, 32'h0);
    check("idle data_out_valid", {31'b0, dvalid}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_status("reset status", 32'h0);

    foreach (vecs[i]) begin
      write_cmd(vecs[i].cmd, 1'b1);
      check($sformatf("vec%0d busy rise", i), {31'b0, busy}, 32'h1);
      if (vecs[i].busy_write) begin
        repeat (100) @(negedge clk);
        write_cmd(8'h00, 1'b0);
        check($sformatf("vec%0d busy after ignored write", i), {31'b0, busy}, 32'h1);
        read_status($sformatf("vec%0d status mid-transfer", i), 32'h1);
      end
      dev_frame(vecs[i].nclk, vecs[i].ack, low_cnt, rel_cyc);
      if (!vecs[i].busy_write)
        check($sformatf("vec%0d inhibit length", i), low_cnt, INH);
      if (vecs[i].nclk < 11) begin
        wait_idle(TO + 200, $sformatf("vec%0d timeout", i));
        check($sformatf("vec%0d timeout latency", i), cyc - rel_cyc, TO);
        exp_q.delete();
      end else begin
        wait_idle(500, $sformatf("vec%0d", i));
        check($sformatf("vec%0d sb drained", i), exp_q.size(), 0);
      end
      repeat (2) @(negedge clk);
      read_status($sformatf("vec%0d status", i), vecs[i].exp_status);
      check($sformatf("vec%0d ps2_clock released", i), {31'b0, ps2_clk}, 32'h1);
      check($sformatf("vec%0d ps2_data released", i), {31'b0, ps2_dat}, 32'h1);
    end

    // Reset while the host is driving a 0 data bit (bit 4 of 0xED).
    write_cmd(PS2_CMD_SET_LEDS, 1'b1);
    dev_frame(5, 1'b1, low_cnt, rel_cyc);
    check("mid-frame data driven low", {31'b0, ps2_dat}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("reset releases ps2_data", {31'b0, ps2_dat}, 32'h1);
    check("reset releases ps2_clock", {31'b0, ps2_clk}, 32'h1);
    check("reset clears busy", {31'b0, busy}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_status("status after reset", 32'h0);
    write_cmd(PS2_CMD_SET_LEDS, 1'b1);
    dev_frame(11, 1'b1, low_cnt, rel_cyc);
    check("post-reset inhibit length", low_cnt, INH);
    wait_idle(500, "post-reset");
    check("post-reset sb drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    read_status("post-reset status", 32'h0);

`ifdef PS2_TX_RETRY_EN
    // NACK first attempt, ACK the retry.
    write_cmd(PS2_CMD_SET_LEDS, 1'b1);
    push_frame(PS2_CMD_SET_LEDS);
    dev_frame(11, 1'b0, low_cnt, rel_cyc);
    dev_frame(11, 1'b1, low_cnt, rel_cyc);
    wait_idle(500, "retry");
    check("retry sb drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    read_status("retry status", 32'h10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
